// File: rtl/prefetch_q_if.sv
// prefetch_q_if: bundles every non-clock/reset signal of the instruction
// prefetch queue.
//   redirect / redirect_pc        : taken branch/jump and its target
//   mem_req / mem_addr            : one outstanding instruction fetch
//   mem_rvalid / mem_rdata        : single-cycle response to that fetch
//   inst_valid / inst / inst_pc   : head of the queue presented to IF
//   inst_ready                    : IF accepts the head this cycle
// The master modport is the queue side; the slave modport is the
// memory/pipeline environment side.
interface prefetch_q_if;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  modport master (
    input  redirect, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
    output mem_req, mem_addr, inst_valid, inst, inst_pc
  );

  modport slave (
    output redirect, redirect_pc, mem_rvalid, mem_rdata, inst_ready,
    input  mem_req, mem_addr, inst_valid, inst, inst_pc
  );
endinterface

// File: rtl/prefetch_q.sv
// prefetch_q: instruction prefetch queue with a single outstanding memory
// request. Fetches sequential words starting at RESET_PC (or at the last
// redirect target) into a DEPTH-entry FIFO and presents the head to IF.
// Ports:
//   clk  : sole clock, all state updates on its rising edge
//   rst  : synchronous active-high reset
//   bus  : prefetch_q_if.master (redirect, memory request/response,
//          head instruction handshake)
module prefetch_q #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic         clk,
  input  logic         rst,
  prefetch_q_if.master bus
);

  localparam int unsigned      PTR_W    = $clog2(DEPTH);
  localparam int unsigned      CNT_W    = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  // DROP: a request is still in flight but its answer belongs to a
  // flushed instruction stream and must be thrown away.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];

  logic             push_s;
  logic             pop_s;
  logic             inst_valid_s;
  logic [CNT_W-1:0] fill_s;

  assign inst_valid_s   = (count_q != CNT_ZERO);
  assign pop_s          = inst_valid_s && bus.inst_ready;
  // Occupancy after the response being accepted now and this cycle's pop;
  // the in-flight slot was reserved, so this never exceeds DEPTH.
  assign fill_s         = count_q + CNT_ONE - (pop_s ? CNT_ONE : CNT_ZERO);

  assign bus.mem_req    = (state_q == WAIT) || (state_q == DROP);
  assign bus.mem_addr   = mem_addr_q;
  assign bus.inst_valid = inst_valid_s;
  assign bus.inst       = inst_valid_s ? data_q[rd_ptr_q] : 32'd0;
  assign bus.inst_pc    = inst_valid_s ? pc_q[rd_ptr_q]   : 32'd0;

  // Next-state, request address and queue bookkeeping.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fetch_pc_d = fetch_pc_q;
    mem_addr_d = mem_addr_q;
    data_d     = data_q;
    pc_d       = pc_q;
    push_s     = 1'b0;

    case (state_q)
      IDLE: begin
        // Launch only when a slot can be reserved; a redirect in IDLE
        // just retargets fetch_pc and the launch follows next cycle.
        if (!bus.redirect && (count_q < CNT_FULL)) begin
          state_d    = WAIT;
          mem_addr_d = fetch_pc_q;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (bus.mem_rvalid) begin
          if (bus.redirect) begin
            state_d = IDLE;
          end else begin
            push_s = 1'b1;
            if (fill_s < CNT_FULL) begin
              state_d    = WAIT;
              mem_addr_d = fetch_pc_q + 32'd4;
            end else begin
              state_d = IDLE;
            end
          end
        end else if (bus.redirect) begin
          state_d = DROP;
        end else begin
          state_d = WAIT;
        end
      end
      DROP: begin
        // The stale answer retires the request even if another redirect
        // arrives alongside it; otherwise we would wait forever.
        if (bus.mem_rvalid) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (bus.redirect) begin
      count_d    = CNT_ZERO;
      rd_ptr_d   = PTR_ZERO;
      wr_ptr_d   = PTR_ZERO;
      fetch_pc_d = bus.redirect_pc;
    end else begin
      if (push_s) begin
        data_d[wr_ptr_q] = bus.mem_rdata;
        pc_d[wr_ptr_q]   = fetch_pc_q;
        wr_ptr_d         = wr_ptr_q + PTR_ONE;
        fetch_pc_d       = fetch_pc_q + 32'd4;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + (push_s ? CNT_ONE : CNT_ZERO) - (pop_s ? CNT_ONE : CNT_ZERO);
    end
  end

  // State, pointers, addresses and queue storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= CNT_ZERO;
      rd_ptr_q   <= PTR_ZERO;
      wr_ptr_q   <= PTR_ZERO;
      fetch_pc_q <= RESET_PC;
      mem_addr_q <= 32'd0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= 32'd0;
        pc_q[i]   <= 32'd0;
      end
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fetch_pc_q <= fetch_pc_d;
      mem_addr_q <= mem_addr_d;
      data_q     <= data_d;
      pc_q       <= pc_d;
    end
  end

endmodule

// File: tb/tb_prefetch_q.sv
// tb_prefetch_q: directed scenarios plus randomized traffic for prefetch_q,
// checked every cycle against a transaction-level reference model built on
// queues (entries) and two flags (request in flight, answer to be dropped).
module tb_prefetch_q;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic clk = 1'b0;
  logic rst;

  prefetch_q_if bus_if();

  prefetch_q #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] mq_pc   [$];
  logic [31:0] mq_data [$];
  logic [31:0] m_fetch;
  logic [31:0] m_addr;
  bit          m_out;
  bit          m_drop;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Apply one rising edge's worth of inputs to the model.
  task automatic model_edge(input bit r, input bit rd, input logic [31:0] rpc,
                            input bit rv, input logic [31:0] rdat, input bit rdy);
    int sz;
    bit pop;
    if (r) begin
      mq_pc.delete();
      mq_data.delete();
      m_fetch = RESET_PC;
      m_addr  = 32'd0;
      m_out   = 1'b0;
      m_drop  = 1'b0;
      return;
    end
    sz  = mq_pc.size();
    pop = (sz != 0) && rdy;
    if (rd) begin
      mq_pc.delete();
      mq_data.delete();
      if (m_out && rv) begin
        m_out  = 1'b0;
        m_drop = 1'b0;
      end else if (m_out) begin
        m_drop = 1'b1;
      end
      m_fetch = rpc;
    end else begin
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_data.pop_front());
      end
      if (!m_out) begin
        if (sz < DEPTH) begin
          m_out  = 1'b1;
          m_addr = m_fetch;
        end
      end else if (rv) begin
        if (m_drop) begin
          m_out  = 1'b0;
          m_drop = 1'b0;
        end else begin
          mq_pc.push_back(m_fetch);
          mq_data.push_back(rdat);
          m_fetch = m_fetch + 32'd4;
          if (mq_pc.size() < DEPTH) m_addr = m_fetch;
          else m_out = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bit v;
    v = (mq_pc.size() != 0);
    check_eq({tag, "_req"},  {31'd0, bus_if.mem_req},    {31'd0, m_out});
    check_eq({tag, "_addr"}, bus_if.mem_addr,            m_addr);
    check_eq({tag, "_vld"},  {31'd0, bus_if.inst_valid}, {31'd0, v});
    check_eq({tag, "_inst"}, bus_if.inst,    v ? mq_data[0] : 32'd0);
    check_eq({tag, "_pc"},   bus_if.inst_pc, v ? mq_pc[0]   : 32'd0);
  endtask

  // Called at a falling edge: drive inputs, clock once, update model, check.
  task automatic step(input string tag, input bit r, input bit rd, input logic [31:0] rpc,
                      input bit rv, input bit rdy);
    logic [31:0] dat;
    dat                = $urandom();
    rst                = r;
    bus_if.redirect    = rd;
    bus_if.redirect_pc = rpc;
    bus_if.mem_rvalid  = rv;
    bus_if.mem_rdata   = dat;
    bus_if.inst_ready  = rdy;
    @(posedge clk);
    model_edge(r, rd, rpc, rv, dat, rdy);
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic reset_dut();
    step("rst", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step("rst", 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
  endtask

  initial begin
    int rdy_pct;
    bit r, rd, rv, rdy;
    logic [31:0] rpc;

    rst                = 1'b1;
    bus_if.redirect    = 1'b0;
    bus_if.redirect_pc = 32'd0;
    bus_if.mem_rvalid  = 1'b0;
    bus_if.mem_rdata   = 32'd0;
    bus_if.inst_ready  = 1'b0;
    @(negedge clk);

    // Reset values, then first request one cycle after IDLE.
    reset_dut();
    check_eq("rst_req",  {31'd0, bus_if.mem_req},    32'd0);
    check_eq("rst_vld",  {31'd0, bus_if.inst_valid}, 32'd0);
    check_eq("rst_inst", bus_if.inst,                32'd0);
    check_eq("rst_pc",   bus_if.inst_pc,             32'd0);
    step("first", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("first_req",  {31'd0, bus_if.mem_req}, 32'd1);
    check_eq("first_addr", bus_if.mem_addr,         RESET_PC);

    // Streaming with single-cycle memory and a never-stalling IF stage.
    for (int i = 0; i < 12; i++) step("stream", 1'b0, 1'b0, 32'd0, bus_if.mem_req, 1'b1);
    check_eq("stream_head", bus_if.inst_pc,  32'd44);
    check_eq("stream_addr", bus_if.mem_addr, 32'd48);

    // Stalled IF: fill to DEPTH, stop, one pop frees exactly one request.
    reset_dut();
    step("fill", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step("fill", 1'b0, 1'b0, 32'd0, bus_if.mem_req, 1'b0);
    check_eq("full_req",  {31'd0, bus_if.mem_req}, 32'd0);
    check_eq("full_head", bus_if.inst_pc,          32'd0);
    step("pop1", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("pop1_head", bus_if.inst_pc, 32'd4);
    step("refill", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("refill_req",  {31'd0, bus_if.mem_req}, 32'd1);
    check_eq("refill_addr", bus_if.mem_addr,         32'h10);
    step("refill", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step("refull", 1'b0, 1'b0, 32'd0, bus_if.mem_req, 1'b0);
    check_eq("refull_req", {31'd0, bus_if.mem_req}, 32'd0);

    // Redirect while waiting: DROP holds the old address, answer discarded.
    reset_dut();
    step("drop", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("drop", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step("drop", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("drop_pre_addr", bus_if.mem_addr, 32'h8);
    step("drop_redir", 1'b0, 1'b1, 32'h40, 1'b0, 1'b1);
    check_eq("drop_req",  {31'd0, bus_if.mem_req},    32'd1);
    check_eq("drop_addr", bus_if.mem_addr,            32'h8);
    check_eq("drop_vld",  {31'd0, bus_if.inst_valid}, 32'd0);
    step("drop", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step("drop", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    step("drop", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    check_eq("drop_done_vld", {31'd0, bus_if.inst_valid}, 32'd0);
    step("drop", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("drop_new_addr", bus_if.mem_addr, 32'h40);
    step("drop", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("drop_new_pc", bus_if.inst_pc, 32'h40);

    // Redirect coinciding with the response: no DROP.
    reset_dut();
    step("rdrv", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("rdrv", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step("rdrv_redir", 1'b0, 1'b1, 32'h40, 1'b1, 1'b0);
    check_eq("rdrv_req", {31'd0, bus_if.mem_req}, 32'd0);
    step("rdrv", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    check_eq("rdrv_addr", bus_if.mem_addr, 32'h40);

    // Three entries, redirect with a pop in the same cycle.
    reset_dut();
    step("flush", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("flush", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step("flush_redir", 1'b0, 1'b1, 32'h80, 1'b0, 1'b1);
    check_eq("flush_vld", {31'd0, bus_if.inst_valid}, 32'd0);
    step("flush", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1);
    step("flush", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1);
    check_eq("flush_addr", bus_if.mem_addr, 32'h80);

    // Reset mid-WAIT followed by a stray response.
    reset_dut();
    step("rstw", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    step("rstw", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    step("rstw_rst", 1'b1, 1'b0, 32'd0, 1'b0, 1'b0);
    step("rstw_stray", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0);
    check_eq("rstw_vld",  {31'd0, bus_if.inst_valid}, 32'd0);
    check_eq("rstw_addr", bus_if.mem_addr,            RESET_PC);

    // Randomized traffic, including targets that wrap past 2^32.
    rdy_pct = 70;
    for (int i = 0; i < 4000; i++) begin
      if ((i % 200) == 0) rdy_pct = $urandom_range(10, 100);
      r   = ($urandom_range(0, 199) == 0);
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'h0000_0FFC);
      rv  = bus_if.mem_req ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 9) == 0);
      rdy = ($urandom_range(1, 100) <= rdy_pct);
      step("rnd", r, rd, rpc, rv, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefetch_q.md
PREFETCH_Q -- requirements
Module: prefetch_q

Interface
REQ-001 Parameter DEPTH, 4, queue entries; SHALL be a power of two, 2..8.
REQ-002 Parameter RESET_PC, 32'd0, first fetch address after reset.
REQ-003 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 redirect  input  1  branch/jump taken; flush queue and restart fetch.
REQ-006 redirect_pc  input  32  new fetch address, valid when redirect=1.
REQ-007 mem_req  output  1  instruction-memory request outstanding.
REQ-008 mem_addr  output  32  word address of the outstanding request.
REQ-009 mem_rvalid  input  1  response for the outstanding request, one cycle wide.
REQ-010 mem_rdata  input  32  instruction word, valid with mem_rvalid.
REQ-011 inst_valid  output  1  head entry available to the IF stage.
REQ-012 inst  output  32  head instruction word.
REQ-013 inst_pc  output  32  address of the head instruction.
REQ-014 inst_ready  input  1  IF stage accepts the head this cycle (low = pipeline stall).

Function
REQ-015 The FSM SHALL have states IDLE, WAIT and DROP; mem_req = (state==WAIT || state==DROP).
REQ-016 mem_addr SHALL be a register, constant while mem_req=1 until the cycle of mem_rvalid.
REQ-017 At most one request SHALL be outstanding; it occupies a reserved queue slot.
REQ-018 IDLE -> WAIT when count < DEPTH: load mem_addr <= fetch_pc.
REQ-019 WAIT with mem_rvalid: push {fetch_pc, mem_rdata}, fetch_pc += 4 (mod 2^32); stay WAIT with mem_addr <= fetch_pc+4 if (count+1-pop) < DEPTH, else go to IDLE.
REQ-020 Pop SHALL occur when inst_valid && inst_ready; the head advances next cycle.
REQ-021 inst_valid = (count != 0); inst and inst_pc SHALL be driven to 0 when inst_valid=0.
REQ-022 A pushed word SHALL first be visible on inst one cycle after the mem_rvalid edge; there is no bypass.
REQ-023 Simultaneous push and pop SHALL leave count unchanged.
REQ-024 Read and write pointers SHALL wrap modulo DEPTH.
REQ-025 redirect SHALL have priority over push and pop: count <= 0, pointers <= 0 and fetch_pc <= redirect_pc.
REQ-026 redirect in WAIT without mem_rvalid -> DROP; mem_req and mem_addr SHALL hold until mem_rvalid.
REQ-027 redirect in WAIT with mem_rvalid -> IDLE; the returned word SHALL be discarded.
REQ-028 In DROP, mem_rvalid data SHALL be discarded; the FSM then goes to IDLE.
REQ-029 redirect while in DROP SHALL update fetch_pc and keep state DROP.
REQ-030 redirect in IDLE SHALL only update fetch_pc and flush the queue.
REQ-031 mem_rvalid while in IDLE SHALL be ignored.
REQ-032 count SHALL never exceed DEPTH; a push SHALL never occur while full.

Reset
REQ-033 On rst=1 at an edge: state=IDLE, count=0, pointers=0, fetch_pc=RESET_PC, mem_addr=0.
REQ-034 On that edge, outputs SHALL become mem_req=0, inst_valid=0, inst=0, inst_pc=0.
REQ-035 rst SHALL override redirect, mem_rvalid and inst_ready in the same cycle.
REQ-036 rst during WAIT or DROP SHALL abandon the transaction; the late mem_rvalid is ignored (REQ-031).
REQ-037 First cycle after rst deasserts: IDLE; mem_req SHALL assert in the following cycle with mem_addr=RESET_PC.

Verification
REQ-038 Reset, memory answers 1 cycle after each request, inst_ready=1 -> mem_addr 0,4,8,... back-to-back; inst_pc 0,4,8 in order with matching inst.
REQ-039 DEPTH=4, inst_ready=0 -> exactly 4 words fetched (addr 0..0xC), then mem_req=0; one pop -> exactly one further request at 0x10.
REQ-040 redirect to 0x40 while WAIT at addr 0x8 with mem_rvalid 3 cycles later -> DROP, mem_addr stays 0x8, word discarded, next request 0x40; inst_valid=0 until 0x40 returns.
REQ-041 redirect to 0x40 in the same cycle as mem_rvalid -> word discarded, DROP skipped, next mem_addr=0x40.
REQ-042 Queue holds 3 entries, redirect and pop in the same cycle -> count=0, inst_valid=0 next cycle.
REQ-043 rst pulse mid-WAIT, then stray mem_rvalid -> queue stays empty; next request addr=RESET_PC.
